dmni_br_rx_queue: RTL and testbench
===================================

// Module: dmni_br_rx_queue
// PURPOSE
//  Parametrised broadcast-receive queue for the DMNI: buffers incoming BR packets
//  {payload, seq_source, ksvc} in N_CH independent circular FIFOs selected by channel.
//  The CPU reads them through a small MMR window decoded by the parent DMNI.
//  Successor to the fixed 16/16/4 single-slot BR payload registers: widths, depth and
//  channel count are generic; adds per-channel IRQ masking and an optional drop mode.
// PARAMETERS
//  PAYLOAD_W  16  payload field width; PAYLOAD_W+SEQ_W <= 32
//  SEQ_W      16  seq_source field width
//  KSVC_W     4   kernel service field width; <= 8
//  DEPTH      4   entries per channel FIFO; power of two, >= 2
//  N_CH       2   channel count, 1..8 (ch 0 = kernel services, ch 1 = monitor)
// PORTS
//  clk_i        in   1                       clock
//  rst_ni       in   1                       async active-low reset
//  rx_valid_i   in   1                       incoming BR packet valid
//  rx_ready_o   out  1                       packet accepted when valid&ready
//  rx_ch_i      in   max(1,$clog2(N_CH))     target channel
//  rx_data_i    in   PAYLOAD_W+SEQ_W+KSVC_W  packed {payload, seq_source, ksvc}
//  mmr_en_i     in   1                       MMR access strobe (one cycle per access)
//  mmr_we_i     in   1                       1 = write, 0 = read
//  mmr_addr_i   in   5                       byte offset in block window
//  mmr_data_i   in   32                      write data
//  mmr_data_o   out  32                      read data, valid 1 cycle after read strobe
//  irq_o        out  1                       |(nonempty & irq_en), registered
// BEHAVIOUR
//  Reset (async): all FIFOs empty, rd/wr pointers 0, SEL=0, IRQ_EN=0, mmr_data_o=0, irq_o=0.
//  MMR map (32-bit words; unlisted offsets read 0, writes ignored):
//   0x00 SEL/HEAD  W: SEL <= data[2:0] (values >= N_CH ignored).
//                  R: {data[31]=nonempty[SEL], [26:24]=SEL, [KSVC_W-1:0]=head ksvc}; no pop
//   0x04 PAYLOAD   R: {payload,seq_source} of SEL head, seq_source in LSBs, zero-extended;
//                  pops that entry. Read on empty channel -> 0, no state change
//   0x08 IRQ_EN    RW, bits [N_CH-1:0]
//   0x0C STATUS    R: [N_CH-1:0]=nonempty, [N_CH+7:8]=full
//   0x10 DROP_CNT  see CONFIGURATION
//  Read latency: 1 cycle; mmr_data_o holds last read value until next read.
//  Push: on valid&ready, entry written at wr_ptr[rx_ch_i], count+1, same edge.
//  rx_ready_o combinational: !full[rx_ch_i]; rx_ch_i >= N_CH -> ready=1, packet dropped.
//  Simultaneous push and pop on same channel: both take effect, count unchanged;
//   when full, push is refused that cycle (ready evaluated on pre-pop state).
//  Pointers are $clog2(DEPTH) bits and wrap naturally; count is $clog2(DEPTH)+1 bits.
//  irq_o updates the cycle after a push/pop/IRQ_EN write changes its inputs.
//  Fields wider than the packed input are never produced; unused read bits are 0.
// CONFIGURATION
//  DMNI_BR_DROP_CNT_EN defined: drop mode. rx_ready_o is constant 1; a packet arriving
//   at a full (or invalid) channel is discarded, FIFO unchanged, and a 16-bit saturating
//   DROP_CNT increments (stays 0xFFFF). 0x10 reads DROP_CNT zero-extended; any write to
//   0x10 clears it; a drop coinciding with the clearing write leaves DROP_CNT=1.
//  DMNI_BR_DROP_CNT_EN undefined: backpressure as above; 0x10 reads 0; no counter logic.
// TESTING
//  1 Reset mid-burst: 3 pushes to ch0, assert rst_ni=0 -> STATUS=0, irq_o=0, ready=1.
//  2 Order/wrap: DEPTH=4, push ksvc 1..6 on ch1 interleaved with 2 early reads
//    -> PAYLOAD reads return seq 1..6 in order, STATUS full bit set only at 4 held.
//  3 Full: 4 pushes ch0, 5th valid -> rx_ready_o=0 (no macro); with macro ready=1,
//    DROP_CNT=1, next PAYLOAD reads still return entries 1..4.
//  4 Same-cycle push+pop on ch0 holding 2 -> count stays 2, popped data = oldest.
//  5 IRQ: push to ch1 with IRQ_EN=0b01 -> irq_o=0; write IRQ_EN=0b10 -> irq_o=1 next
//    cycle; pop last entry -> irq_o=0 one cycle later.
//  6 Empty read: SEL=1 empty, read 0x04 -> 0x00000000, pointers unchanged, HEAD bit31=0.

Source files
------------

// File: rtl/dmni_br_rx_queue.sv
// Broadcast-receive queue: N_CH circular FIFOs of {payload, seq_source, ksvc} read via a small MMR window.
// Optional macro DMNI_BR_DROP_CNT_EN: drop mode with saturating DROP_CNT instead of backpressure.
module dmni_br_rx_queue #(
    parameter int PAYLOAD_W = 16,
    parameter int SEQ_W     = 16,
    parameter int KSVC_W    = 4,
    parameter int DEPTH     = 4,
    parameter int N_CH      = 2,
    localparam int CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1,
    localparam int PKT_W    = PAYLOAD_W + SEQ_W + KSVC_W
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             rx_valid_i,
    output logic             rx_ready_o,
    input  logic [CH_W-1:0]  rx_ch_i,
    input  logic [PKT_W-1:0] rx_data_i,
    input  logic             mmr_en_i,
    input  logic             mmr_we_i,
    input  logic [4:0]       mmr_addr_i,
    input  logic [31:0]      mmr_data_i,
    output logic [31:0]      mmr_data_o,
    output logic             irq_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [4:0] ADDR_HEAD    = 5'h00;
    localparam logic [4:0] ADDR_PAYLOAD = 5'h04;
    localparam logic [4:0] ADDR_IRQ_EN  = 5'h08;
    localparam logic [4:0] ADDR_STATUS  = 5'h0C;
    localparam logic [4:0] ADDR_DROP    = 5'h10;

    logic [PKT_W-1:0] mem_q    [N_CH][DEPTH];
    logic [PKT_W-1:0] mem_d    [N_CH][DEPTH];
    logic [PTR_W-1:0] wr_ptr_q [N_CH];
    logic [PTR_W-1:0] wr_ptr_d [N_CH];
    logic [PTR_W-1:0] rd_ptr_q [N_CH];
    logic [PTR_W-1:0] rd_ptr_d [N_CH];
    logic [CNT_W-1:0] cnt_q    [N_CH];
    logic [CNT_W-1:0] cnt_d    [N_CH];

    logic [2:0]       sel_q, sel_d;
    logic [N_CH-1:0]  irq_en_q, irq_en_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             irq_q, irq_d;

    logic [N_CH-1:0]  nonempty, full, rx_hit, sel_hit;
    logic             rx_ch_ok, rx_full_sel, accept;
    logic             head_ne;
    logic [PKT_W-1:0] head_pkt;
    logic             mmr_rd, mmr_wr, pop;

`ifdef DMNI_BR_DROP_CNT_EN
    logic [15:0]      drop_cnt_q, drop_cnt_d;
    logic             drop;
`endif

    // Upper write-data bits beyond the register fields have no destination.
    logic unused_wdata;
    assign unused_wdata = ^mmr_data_i;

    always_comb begin
        nonempty    = '0;
        full        = '0;
        rx_hit      = '0;
        sel_hit     = '0;
        head_ne     = 1'b0;
        head_pkt    = '0;
        for (int c = 0; c < N_CH; c++) begin
            nonempty[c] = (cnt_q[c] != '0);
            full[c]     = (cnt_q[c] == CNT_W'(DEPTH));
            rx_hit[c]   = (rx_ch_i == CH_W'(c));
            sel_hit[c]  = (sel_q == 3'(c));
            if (sel_hit[c]) begin
                head_ne  = nonempty[c];
                head_pkt = mem_q[c][rd_ptr_q[c]];
            end
        end
        rx_ch_ok    = |rx_hit;
        rx_full_sel = |(rx_hit & full);
    end

    assign mmr_rd = mmr_en_i && !mmr_we_i;
    assign mmr_wr = mmr_en_i && mmr_we_i;
    assign pop    = mmr_rd && (mmr_addr_i == ADDR_PAYLOAD) && head_ne;
    assign accept = rx_valid_i && rx_ch_ok && !rx_full_sel;

`ifdef DMNI_BR_DROP_CNT_EN
    assign rx_ready_o = 1'b1;
    assign drop       = rx_valid_i && !accept;
`else
    // Invalid channels report ready so the sender never stalls on a packet nobody will take.
    assign rx_ready_o = !rx_full_sel;
`endif

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        for (int c = 0; c < N_CH; c++) begin
            if (accept && rx_hit[c]) begin
                mem_d[c][wr_ptr_q[c]] = rx_data_i;
                wr_ptr_d[c]           = wr_ptr_q[c] + 1'b1;
            end
            if (pop && sel_hit[c]) begin
                rd_ptr_d[c] = rd_ptr_q[c] + 1'b1;
            end
            case ({accept && rx_hit[c], pop && sel_hit[c]})
                2'b10:   cnt_d[c] = cnt_q[c] + CNT_W'(1);
                2'b01:   cnt_d[c] = cnt_q[c] - CNT_W'(1);
                default: cnt_d[c] = cnt_q[c];
            endcase
        end
    end

    always_comb begin
        sel_d    = sel_q;
        irq_en_d = irq_en_q;
        if (mmr_wr && (mmr_addr_i == ADDR_HEAD)) begin
            for (int c = 0; c < N_CH; c++) begin
                if (mmr_data_i[2:0] == 3'(c)) begin
                    sel_d = mmr_data_i[2:0];
                end
            end
        end
        if (mmr_wr && (mmr_addr_i == ADDR_IRQ_EN)) begin
            irq_en_d = mmr_data_i[N_CH-1:0];
        end
        irq_d = |(nonempty & irq_en_q);
    end

    always_comb begin
        rdata_d = rdata_q;
        if (mmr_rd) begin
            rdata_d = '0;
            case (mmr_addr_i)
                ADDR_HEAD: begin
                    rdata_d[31]    = head_ne;
                    rdata_d[26:24] = sel_q;
                    if (head_ne) begin
                        rdata_d[KSVC_W-1:0] = head_pkt[KSVC_W-1:0];
                    end
                end
                ADDR_PAYLOAD: begin
                    if (head_ne) begin
                        rdata_d = 32'(head_pkt[PKT_W-1:KSVC_W]);
                    end
                end
                ADDR_IRQ_EN: rdata_d[N_CH-1:0] = irq_en_q;
                ADDR_STATUS: begin
                    rdata_d[N_CH-1:0]   = nonempty;
                    rdata_d[N_CH+7:8]   = full;
                end
`ifdef DMNI_BR_DROP_CNT_EN
                ADDR_DROP:   rdata_d[15:0] = drop_cnt_q;
`endif
                default:     rdata_d = '0;
            endcase
        end
    end

`ifdef DMNI_BR_DROP_CNT_EN
    // A drop in the same cycle as the clearing write is counted after the clear.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (mmr_wr && (mmr_addr_i == ADDR_DROP)) begin
            drop_cnt_d = drop ? 16'd1 : 16'd0;
        end else if (drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int c = 0; c < N_CH; c++) begin
                wr_ptr_q[c] <= '0;
                rd_ptr_q[c] <= '0;
                cnt_q[c]    <= '0;
            end
            sel_q    <= '0;
            irq_en_q <= '0;
            rdata_q  <= '0;
            irq_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            sel_q    <= sel_d;
            irq_en_q <= irq_en_d;
            rdata_q  <= rdata_d;
            irq_q    <= irq_d;
        end
    end

    // Entry storage carries no reset; occupancy is tracked by the counters alone.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    assign mmr_data_o = rdata_q;
    assign irq_o      = irq_q;

endmodule

// File: tb/tb_dmni_br_rx_queue.sv
// Scoreboard bench for dmni_br_rx_queue: reads queue expected values, a monitor compares mmr_data_o.
module tb_dmni_br_rx_queue;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        rx_valid_i;
    logic        rx_ready_o;
    logic [0:0]  rx_ch_i;
    logic [35:0] rx_data_i;
    logic        mmr_en_i;
    logic        mmr_we_i;
    logic [4:0]  mmr_addr_i;
    logic [31:0] mmr_data_i;
    logic [31:0] mmr_data_o;
    logic        irq_o;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] sb_exp  [$];
    string       sb_name [$];

    dmni_br_rx_queue dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .rx_valid_i (rx_valid_i),
        .rx_ready_o (rx_ready_o),
        .rx_ch_i    (rx_ch_i),
        .rx_data_i  (rx_data_i),
        .mmr_en_i   (mmr_en_i),
        .mmr_we_i   (mmr_we_i),
        .mmr_addr_i (mmr_addr_i),
        .mmr_data_i (mmr_data_i),
        .mmr_data_o (mmr_data_o),
        .irq_o      (irq_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Packet n: payload 0xA000|n, seq_source n, ksvc n.
    function automatic logic [35:0] pkt(input int n);
        logic [15:0] pl;
        pl = 16'hA000 | 16'(n);
        return {pl, 16'(n), 4'(n)};
    endfunction

    function automatic logic [31:0] pl_word(input int n);
        logic [15:0] pl;
        pl = 16'hA000 | 16'(n);
        return {pl, 16'(n)};
    endfunction

    // Monitor: every accepted read strobe yields one word on mmr_data_o a cycle later.
    initial begin
        forever begin
            @(posedge clk);
            if (rst_ni && mmr_en_i && !mmr_we_i) begin
                #1;
                if (sb_exp.size() == 0) begin
                    check("unexpected_read", mmr_data_o, 32'hDEAD_BEEF);
                end else begin
                    check(sb_name.pop_front(), mmr_data_o, sb_exp.pop_front());
                end
            end
        end
    end

    task automatic push_pkt(input int ch, input int n, input logic exp_rdy, input string name);
        rx_valid_i = 1'b1;
        rx_ch_i    = 1'(ch);
        rx_data_i  = pkt(n);
        #1;
        check(name, {31'd0, rx_ready_o}, {31'd0, exp_rdy});
        @(negedge clk);
        rx_valid_i = 1'b0;
    endtask

    task automatic mmr_read(input logic [4:0] addr, input logic [31:0] exp, input string name);
        mmr_en_i   = 1'b1;
        mmr_we_i   = 1'b0;
        mmr_addr_i = addr;
        sb_exp.push_back(exp);
        sb_name.push_back(name);
        @(negedge clk);
        mmr_en_i = 1'b0;
    endtask

    task automatic mmr_write(input logic [4:0] addr, input logic [31:0] data);
        mmr_en_i   = 1'b1;
        mmr_we_i   = 1'b1;
        mmr_addr_i = addr;
        mmr_data_i = data;
        @(negedge clk);
        mmr_en_i = 1'b0;
        mmr_we_i = 1'b0;
    endtask

    initial begin
        rst_ni     = 1'b0;
        rx_valid_i = 1'b0;
        rx_ch_i    = '0;
        rx_data_i  = '0;
        mmr_en_i   = 1'b0;
        mmr_we_i   = 1'b0;
        mmr_addr_i = '0;
        mmr_data_i = '0;
        repeat (2) @(negedge clk);
        check("rst_rdata", mmr_data_o, 32'h0);
        check("rst_irq", {31'd0, irq_o}, 32'd0);
        check("rst_ready", {31'd0, rx_ready_o}, 32'd1);
        rst_ni = 1'b1;
        @(negedge clk);

        // Reset in the middle of a burst
        push_pkt(0, 1, 1'b1, "t1_rdy1");
        push_pkt(0, 2, 1'b1, "t1_rdy2");
        push_pkt(0, 3, 1'b1, "t1_rdy3");
        mmr_read(5'h0C, 32'h0000_0001, "t1_status_pre");
        rst_ni = 1'b0;
        #1;
        check("t1_ready_in_rst", {31'd0, rx_ready_o}, 32'd1);
        check("t1_irq_in_rst", {31'd0, irq_o}, 32'd0);
        check("t1_rdata_in_rst", mmr_data_o, 32'h0);
        @(negedge clk);
        rst_ni = 1'b1;
        @(negedge clk);
        mmr_read(5'h0C, 32'h0, "t1_status_post");

        // Ordering and pointer wrap on ch1
        mmr_write(5'h00, 32'd1);
        push_pkt(1, 1, 1'b1, "t2_rdy1");
        push_pkt(1, 2, 1'b1, "t2_rdy2");
        mmr_read(5'h04, pl_word(1), "t2_pl1");
        push_pkt(1, 3, 1'b1, "t2_rdy3");
        mmr_read(5'h04, pl_word(2), "t2_pl2");
        push_pkt(1, 4, 1'b1, "t2_rdy4");
        push_pkt(1, 5, 1'b1, "t2_rdy5");
        mmr_read(5'h0C, 32'h0000_0002, "t2_status3");
        push_pkt(1, 6, 1'b1, "t2_rdy6");
        mmr_read(5'h0C, 32'h0000_0202, "t2_status_full");
        mmr_read(5'h00, 32'h8100_0003, "t2_head");
        for (int n = 3; n <= 6; n++) begin
            mmr_read(5'h04, pl_word(n), $sformatf("t2_pl%0d", n));
        end
        mmr_read(5'h0C, 32'h0, "t2_status_empty");

        // Full channel: backpressure or drop
        mmr_write(5'h00, 32'd0);
        for (int n = 1; n <= 4; n++) begin
            push_pkt(0, n, 1'b1, $sformatf("t3_rdy%0d", n));
        end
`ifdef DMNI_BR_DROP_CNT_EN
        push_pkt(0, 5, 1'b1, "t3_rdy_full");
        mmr_read(5'h10, 32'd1, "t3_dropcnt");
`else
        push_pkt(0, 5, 1'b0, "t3_rdy_full");
        mmr_read(5'h10, 32'd0, "t3_dropcnt");
`endif
        mmr_read(5'h0C, 32'h0000_0101, "t3_status_full");
        for (int n = 1; n <= 4; n++) begin
            mmr_read(5'h04, pl_word(n), $sformatf("t3_pl%0d", n));
        end
        mmr_write(5'h10, 32'h0);
        mmr_read(5'h10, 32'd0, "t3_dropcnt_clr");

        // Same-cycle push and pop on ch0 holding 2
        push_pkt(0, 1, 1'b1, "t4_rdy1");
        push_pkt(0, 2, 1'b1, "t4_rdy2");
        rx_valid_i = 1'b1;
        rx_ch_i    = 1'b0;
        rx_data_i  = pkt(3);
        mmr_read(5'h04, pl_word(1), "t4_pop_oldest");
        rx_valid_i = 1'b0;
        mmr_read(5'h0C, 32'h0000_0001, "t4_status");
        mmr_read(5'h04, pl_word(2), "t4_pl2");
        mmr_read(5'h04, pl_word(3), "t4_pl3");
        mmr_read(5'h0C, 32'h0, "t4_status_empty");

        // IRQ masking and timing
        mmr_write(5'h08, 32'h1);
        push_pkt(1, 7, 1'b1, "t5_rdy");
        @(negedge clk);
        check("t5_irq_masked", {31'd0, irq_o}, 32'd0);
        mmr_write(5'h08, 32'h2);
        check("t5_irq_same", {31'd0, irq_o}, 32'd0);
        @(negedge clk);
        check("t5_irq_on", {31'd0, irq_o}, 32'd1);
        mmr_read(5'h08, 32'h2, "t5_irq_en");
        mmr_write(5'h00, 32'd1);
        mmr_read(5'h04, pl_word(7), "t5_pl7");
        check("t5_irq_hold", {31'd0, irq_o}, 32'd1);
        @(negedge clk);
        check("t5_irq_off", {31'd0, irq_o}, 32'd0);

        // Empty read, unmapped offset, ignored SEL write
        mmr_read(5'h04, 32'h0, "t6_empty_pl");
        mmr_read(5'h00, 32'h0100_0000, "t6_empty_head");
        mmr_read(5'h14, 32'h0, "t6_unmapped");
        mmr_write(5'h00, 32'd5);
        mmr_read(5'h00, 32'h0100_0000, "t6_sel_ignored");
        @(negedge clk);
        check("t6_rdata_hold", mmr_data_o, 32'h0100_0000);
        push_pkt(1, 8, 1'b1, "t6_rdy");
        mmr_read(5'h00, 32'h8100_0008, "t6_head");
        mmr_read(5'h04, pl_word(8), "t6_pl8");
        mmr_read(5'h0C, 32'h0, "t6_status");

        for (int i = 0; i < 10 && sb_exp.size() != 0; i++) begin
            @(negedge clk);
        end
        if (sb_exp.size() != 0) begin
            check("sb_drain", 32'(sb_exp.size()), 32'd0);
        end
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
